multicycle_control: RTL and testbench

Moore-style main controller for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps, driving all datapath enables and mux selects from a registered state, and stalls on a shared instruction/data memory via a ready handshake. Supports R-type, lw, sw, addi, addiu, ori, andi, beq and j.

---
 rtl/mc_pkg.sv | 73 +++++++
 rtl/mc_decode.sv | 39 +++
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multi-cycle MIPS main controller:
//               FSM state codes, opcode constants, ALUOp / ALUSrcB / PCSource
//               encodings and the instruction-class enum produced by decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  // FSM state codes
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_I_EXEC   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp encodings
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b101;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction class; addi and addiu share a class since the controller
  // treats them identically (overflow handling lives in the datapath).
  typedef enum logic [3:0] {
    CLS_NONE = 4'd0,
    CLS_R    = 4'd1,
    CLS_LW   = 4'd2,
    CLS_SW   = 4'd3,
    CLS_ADDI = 4'd4,
    CLS_ORI  = 4'd5,
    CLS_ANDI = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_J    = 4'd8
  } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module      : mc_decode
// Description : Combinational opcode classifier. Maps IR[31:26] to an
//               instruction class and flags opcodes the controller does not
//               support.
// Ports       : i_opcode  [5:0] in  - instruction opcode
//               o_class         out - instruction class (CLS_NONE if illegal)
//               o_illegal       out - opcode not supported
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   i_opcode,
  output instr_class_t o_class,
  output logic         o_illegal
);

  always_comb begin
    o_class   = CLS_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE:          o_class = CLS_R;
      OP_LW:             o_class = CLS_LW;
      OP_SW:             o_class = CLS_SW;
      OP_ADDI, OP_ADDIU: o_class = CLS_ADDI;
      OP_ORI:            o_class = CLS_ORI;
      OP_ANDI:           o_class = CLS_ANDI;
      OP_BEQ:            o_class = CLS_BEQ;
      OP_J:              o_class = CLS_J;
      default:           o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Moore-style main controller for the multi-cycle MIPS datapath.
//               Steps each instruction through fetch / decode / execute /
//               memory / write-back and stalls on the shared memory via
//               mem_ready.
// Ports       : clk, reset (sync, active-high), opcode[5:0], mem_ready in;
//               PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0],
//               ALUOp[2:0], PCSource[1:0], Sign, instr_done, illegal_op out.
// Config      : MULTICYCLE_TRAP_EN - when defined, an unsupported opcode
//               parks the FSM in TRAP (illegal_op held high) until reset;
//               otherwise it is retired as a NOP with a one-cycle
//               illegal_op pulse in DECODE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Sign,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [3:0]   r_state;
  logic [3:0]   w_next;
  instr_class_t r_class;
  instr_class_t w_class;
  logic         w_illegal;

  mc_decode u_decode (
    .i_opcode (opcode),
    .o_class  (w_class),
    .o_illegal(w_illegal)
  );

  // Class is latched in DECODE so later states do not depend on the opcode
  // input, which is only valid while the IR is stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_class <= CLS_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_class;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_class)
          CLS_LW, CLS_SW:             w_next = S_MEM_ADDR;
          CLS_R:                      w_next = S_R_EXEC;
          CLS_ADDI, CLS_ORI, CLS_ANDI: w_next = S_I_EXEC;
          CLS_BEQ:                    w_next = S_BRANCH;
          CLS_J:                      w_next = S_JUMP;
          default: begin
`ifdef MULTICYCLE_TRAP_EN
            w_next = S_TRAP;
`else
            w_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR: w_next = (r_class == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Output decode: everything comes from r_state except the handshake-
  // qualified IRWrite/PCWrite in FETCH, instr_done in MEM_WR and the
  // NOP-retire flags in DECODE.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    PCSource    = PCSRC_ALU;
    Sign        = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = SRCB_IMM_SH;
        Sign    = 1'b1;
`ifndef MULTICYCLE_TRAP_EN
        illegal_op = w_illegal;
        instr_done = w_illegal;
`endif
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        Sign    = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (r_class)
          CLS_ORI:  ALUOp = ALU_OR;
          CLS_ANDI: ALUOp = ALU_AND;
          default: begin
            ALUOp = ALU_ADDI;
            Sign  = 1'b1;
          end
        endcase
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each directed
//               step queues the expected control vector for one clock cycle
//               together with the mem_ready/reset values for that cycle; the
//               queue is then drained cycle by cycle against the DUT.
//               Honors MULTICYCLE_TRAP_EN for the illegal-opcode case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, Sign, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  int checks   = 0;
  int failures = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .Sign       (Sign),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Observed vector, field order matches pk() below.
  logic [19:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, Sign, instr_done, illegal_op};

  typedef struct {
    logic [19:0] e;
    bit          rdy;
    bit          rst;
    string       tag;
  } step_t;

  step_t sq[$];

  function automatic logic [19:0] pk(
    bit pcw, bit pcwc, bit iord, bit mr, bit mw, bit irw, bit rdst, bit m2r,
    bit rw, bit srca, logic [1:0] srcb, logic [2:0] aop, logic [1:0] pcs,
    bit sgn, bit done, bit ill);
    return {pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, srca, srcb, aop,
            pcs, sgn, done, ill};
  endfunction

  // Expected per-state vectors, written straight from the state table.
  function automatic logic [19:0] v_fetch(bit r);
    return pk(r,0,0,1,0,r,0,0,0,0,2'b01,3'b000,2'b00,0,0,0);
  endfunction
  function automatic logic [19:0] v_decode(bit nop_ill);
    return pk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1,nop_ill,nop_ill);
  endfunction
  function automatic logic [19:0] v_memaddr();
    return pk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,1,0,0);
  endfunction
  function automatic logic [19:0] v_memrd();
    return pk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
  endfunction
  function automatic logic [19:0] v_memwb();
    return pk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1,0);
  endfunction
  function automatic logic [19:0] v_memwr(bit r);
    return pk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,r,0);
  endfunction
  function automatic logic [19:0] v_rexec();
    return pk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0,0);
  endfunction
  function automatic logic [19:0] v_rwb();
    return pk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1,0);
  endfunction
  function automatic logic [19:0] v_iexec(logic [2:0] aop, bit sgn);
    return pk(0,0,0,0,0,0,0,0,0,1,2'b10,aop,2'b00,sgn,0,0);
  endfunction
  function automatic logic [19:0] v_iwb();
    return pk(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0);
  endfunction
  function automatic logic [19:0] v_branch();
    return pk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,1,0);
  endfunction
  function automatic logic [19:0] v_jump();
    return pk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,1,0);
  endfunction
  function automatic logic [19:0] v_trap();
    return pk(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,1);
  endfunction

  task automatic push(logic [19:0] e, bit rdy, bit rst, string tag);
    step_t s;
    s.e = e; s.rdy = rdy; s.rst = rst; s.tag = tag;
    sq.push_back(s);
  endtask

  // Drain the scoreboard: drive this cycle's inputs, compare, advance.
  task automatic run_queue();
    step_t s;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy;
      reset     = s.rst;
      #2;
      checks++;
      assert (obs === s.e) else begin
        failures++;
        $error("FAIL %s observed=%05h expected=%05h", s.tag, obs, s.e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: FETCH values, stalling while mem_ready is low.
    push(v_fetch(0), 0, 0, "reset_fetch_stall");
    run_queue();

    // add: 4 cycles
    opcode = 6'b000000;
    push(v_fetch(1),   1, 0, "add_fetch");
    push(v_decode(0),  1, 0, "add_decode");
    push(v_rexec(),    0, 0, "add_rexec_ready_ignored");
    push(v_rwb(),      1, 0, "add_rwb");
    run_queue();

    // lw with 2 stall cycles in MEM_RD: 7 cycles
    opcode = 6'b100011;
    push(v_fetch(1),   1, 0, "lw_fetch");
    push(v_decode(0),  1, 0, "lw_decode");
    push(v_memaddr(),  1, 0, "lw_memaddr");
    push(v_memrd(),    0, 0, "lw_memrd_stall1");
    push(v_memrd(),    0, 0, "lw_memrd_stall2");
    push(v_memrd(),    1, 0, "lw_memrd_ready");
    push(v_memwb(),    1, 0, "lw_memwb");
    run_queue();

    // sw with a fetch stall and a write stall
    opcode = 6'b101011;
    push(v_fetch(0),   0, 0, "sw_fetch_stall");
    push(v_fetch(1),   1, 0, "sw_fetch");
    push(v_decode(0),  1, 0, "sw_decode");
    push(v_memaddr(),  1, 0, "sw_memaddr");
    push(v_memwr(0),   0, 0, "sw_memwr_stall");
    push(v_memwr(1),   1, 0, "sw_memwr_ready");
    run_queue();

    // beq: 3 cycles, mem_ready ignored in BRANCH
    opcode = 6'b000100;
    push(v_fetch(1),   1, 0, "beq_fetch");
    push(v_decode(0),  1, 0, "beq_decode");
    push(v_branch(),   0, 0, "beq_branch");
    run_queue();

    // j: 3 cycles
    opcode = 6'b000010;
    push(v_fetch(1),   1, 0, "j_fetch");
    push(v_decode(0),  1, 0, "j_decode");
    push(v_jump(),     1, 0, "j_jump");
    run_queue();

    // ori: zero-extend, OR
    opcode = 6'b001101;
    push(v_fetch(1),           1, 0, "ori_fetch");
    push(v_decode(0),          1, 0, "ori_decode");
    push(v_iexec(3'b100, 0),   1, 0, "ori_iexec");
    push(v_iwb(),              1, 0, "ori_iwb");
    run_queue();

    // addi: sign-extend, add-imm
    opcode = 6'b001000;
    push(v_fetch(1),           1, 0, "addi_fetch");
    push(v_decode(0),          1, 0, "addi_decode");
    push(v_iexec(3'b011, 1),   1, 0, "addi_iexec");
    push(v_iwb(),              1, 0, "addi_iwb");
    run_queue();

    // andi: zero-extend, AND
    opcode = 6'b001100;
    push(v_fetch(1),           1, 0, "andi_fetch");
    push(v_decode(0),          1, 0, "andi_decode");
    push(v_iexec(3'b101, 0),   1, 0, "andi_iexec");
    push(v_iwb(),              1, 0, "andi_iwb");
    run_queue();

    // Reset asserted mid MEM_RD stall: FETCH on the next cycle.
    opcode = 6'b100011;
    push(v_fetch(1),   1, 0, "lwrst_fetch");
    push(v_decode(0),  1, 0, "lwrst_decode");
    push(v_memaddr(),  1, 0, "lwrst_memaddr");
    push(v_memrd(),    0, 0, "lwrst_memrd_stall");
    push(v_memrd(),    0, 1, "lwrst_memrd_reset");
    push(v_fetch(0),   0, 0, "lwrst_after_reset");
    run_queue();

    // Unsupported opcode
    opcode = 6'b111111;
    push(v_fetch(1),   1, 0, "ill_fetch");
`ifdef MULTICYCLE_TRAP_EN
    push(v_decode(0),  1, 0, "ill_decode");
    push(v_trap(),     1, 0, "ill_trap1");
    push(v_trap(),     0, 0, "ill_trap2");
    push(v_trap(),     1, 0, "ill_trap3");
    push(v_trap(),     1, 1, "ill_trap_reset");
    push(v_fetch(0),   0, 0, "ill_after_reset");
`else
    push(v_decode(1),  1, 0, "ill_decode_pulse");
    push(v_fetch(0),   0, 0, "ill_back_fetch");
`endif
    run_queue();

    // A normal instruction still works afterwards.
    opcode = 6'b000010;
    push(v_fetch(1),   1, 0, "post_j_fetch");
    push(v_decode(0),  1, 0, "post_j_decode");
    push(v_jump(),     1, 0, "post_j_jump");
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
